// File: rtl/atom_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atom_mem_pkg
// Brief    : Shared constants and types for the Atom memory arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package atom_mem_pkg;

    localparam int ADDR_W     = 18;
    localparam int MEM_DEPTH  = 196608;
    localparam int PAGE_SHIFT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/atom_page_decode.sv
`default_nettype none
// ============================================================================
// Module   : atom_page_decode
// Brief    : Address range check and write permission for one access.
//            ROM write-protect for CPU writes is enabled by ATOM_ROM_WP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module atom_page_decode #(
    parameter int          ADDR_W        = atom_mem_pkg::ADDR_W,
    parameter int          MEM_DEPTH     = atom_mem_pkg::MEM_DEPTH,
    parameter logic [47:0] ROM_PAGE_MASK = 48'hF4C0_007F_F000
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              is_cpu,
    output logic              in_range,
    output logic              write_ok
);
    import atom_mem_pkg::*;

    localparam int c_page_w = ADDR_W - PAGE_SHIFT;
    localparam int c_pages  = 1 << c_page_w;
    // Widened to one bit per possible page so every page index is legal
    localparam logic [c_pages-1:0] c_mask_ext = c_pages'(ROM_PAGE_MASK);

    logic [c_page_w-1:0] w_page;
    logic                w_rom_page;

    assign w_page     = addr[ADDR_W-1:PAGE_SHIFT];
    assign w_rom_page = c_mask_ext[w_page];
    assign in_range   = 32'(addr) < 32'(MEM_DEPTH);

`ifdef ATOM_ROM_WP_EN
    assign write_ok = we && in_range && !(is_cpu && w_rom_page);
`else
    logic w_unused;
    assign w_unused = is_cpu ^ w_rom_page;
    assign write_ok = we && in_range;
`endif

endmodule
`default_nettype wire

// File: rtl/atom_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : atom_mem_arbiter
// Brief    : Serialises CPU and loader accesses to the single-port Atom RAM
//            with a fixed 4-cycle access and loader anti-starvation.
//            Optional macro: ATOM_ROM_WP_EN (CPU write-protect of ROM pages).
// Revision : 1.0 - initial release
// ============================================================================
module atom_mem_arbiter #(
    parameter int          ADDR_W        = atom_mem_pkg::ADDR_W,
    parameter int          MEM_DEPTH     = atom_mem_pkg::MEM_DEPTH,
    parameter int          STARVE_MAX    = 4,
    parameter logic [47:0] ROM_PAGE_MASK = 48'hF4C0_007F_F000
) (
    input  logic              clk_42,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_wdata,
    output logic              ldr_ack,
    output logic [7:0]        ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    input  logic [7:0]        mem_dout,
    output logic              busy
);
    import atom_mem_pkg::*;

    localparam int                 c_cnt_w      = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

    state_t              r_state;
    state_t              w_state_nxt;
    owner_t              r_owner;
    logic                r_in_range;
    logic                r_is_read;
    logic [c_cnt_w-1:0]  r_starve;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_din;
    logic                r_mem_we;
    logic [7:0]          r_cpu_rdata;
    logic [7:0]          r_ldr_rdata;

    logic                w_grant;
    logic                w_pick_ldr;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [7:0]          w_sel_wdata;
    logic                w_in_range;
    logic                w_write_ok;
    logic [7:0]          w_rdata;

    // Loader wins when alone or once the CPU has had its STARVE_MAX turns
    always_comb begin
        w_grant     = cpu_req || ldr_req;
        w_pick_ldr  = ldr_req && (!cpu_req || (r_starve == c_starve_max));
        w_sel_we    = w_pick_ldr ? ldr_we    : cpu_we;
        w_sel_addr  = w_pick_ldr ? ldr_addr  : cpu_addr;
        w_sel_wdata = w_pick_ldr ? ldr_wdata : cpu_wdata;
    end

    atom_page_decode #(
        .ADDR_W        (ADDR_W),
        .MEM_DEPTH     (MEM_DEPTH),
        .ROM_PAGE_MASK (ROM_PAGE_MASK)
    ) u_page_decode (
        .addr     (w_sel_addr),
        .we       (w_sel_we),
        .is_cpu   (!w_pick_ldr),
        .in_range (w_in_range),
        .write_ok (w_write_ok)
    );

    always_ff @(posedge clk_42) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        cpu_ack     = 1'b0;
        ldr_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_grant) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: w_state_nxt = LATCH;
            LATCH: w_state_nxt = DONE;
            DONE: begin
                w_state_nxt = IDLE;
                cpu_ack     = (r_owner == OWN_CPU);
                ldr_ack     = (r_owner == OWN_LDR);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_rdata = r_in_range ? mem_dout : 8'hFF;

    always_ff @(posedge clk_42) begin
        if (reset) begin
            r_owner     <= OWN_CPU;
            r_in_range  <= 1'b0;
            r_is_read   <= 1'b0;
            r_starve    <= '0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_we    <= 1'b0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner    <= w_pick_ldr ? OWN_LDR : OWN_CPU;
                        r_mem_addr <= w_sel_addr;
                        r_mem_din  <= w_sel_wdata;
                        r_mem_we   <= w_write_ok;
                        r_in_range <= w_in_range;
                        r_is_read  <= !w_sel_we;
                    end
                    // Only a CPU grant with the loader waiting advances the count
                    if (!ldr_req || w_pick_ldr) begin
                        r_starve <= '0;
                    end else begin
                        r_starve <= r_starve + c_cnt_w'(1);
                    end
                end
                LATCH: begin
                    if (r_is_read) begin
                        if (r_owner == OWN_CPU) begin
                            r_cpu_rdata <= w_rdata;
                        end else begin
                            r_ldr_rdata <= w_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_we    = r_mem_we;
    assign cpu_rdata = r_cpu_rdata;
    assign ldr_rdata = r_ldr_rdata;

endmodule
`default_nettype wire
